// File: rtl/parking_meter_ctrl.sv
// parking_meter_ctrl: parking-time counter with 1 s decrement, double-dabble BCD output and display blanking.
// Define METER_FLASH_EN to build the low-time/expired flash logic; otherwise blank is tied low.
module parking_meter_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int MAX_TIME   = 9999,
  parameter int LOW_THRESH = 180
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        add30,
  input  logic        add120,
  input  logic        add180,
  input  logic        add300,
  input  logic        rst15,
  input  logic        rst185,
  output logic [15:0] bcd_out,
  output logic        blank,
  output logic        busy
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc;
  logic [13:0] tm, tm_n, cap, last, bin;
  logic [14:0] sum, sat;
  logic [15:0] bcd, bcd_adj;
  logic [3:0] cnt;
  logic tick, preset, restart, write, blank_n;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign preset = rst15 | rst185;
  assign sum = {1'b0, tm} + (add30 ? 15'd30 : 15'd0) + (add120 ? 15'd120 : 15'd0)
             + (add180 ? 15'd180 : 15'd0) + (add300 ? 15'd300 : 15'd0);
  assign sat = sum > 15'(MAX_TIME) ? 15'(MAX_TIME) : sum;
  assign tm_n = rst185 ? 14'd185 : rst15 ? 14'd15 : (tick && sat != 15'd0) ? 14'(sat - 15'd1) : sat[13:0];
  assign busy = state != IDLE;
  for (genvar d = 0; d < 4; d++)
    assign bcd_adj[4*d +: 4] = bcd[4*d +: 4] >= 4'd5 ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
  // A conversion in flight is abandoned whenever time moves away from the captured value.
  always_comb begin
    restart = state == IDLE ? tm != last : tm != cap;
    write = state == DONE && !restart;
    state_n = restart ? SHIFT : (state == SHIFT && cnt == 4'd13) ? DONE : state == DONE ? IDLE : state;
  end
`ifdef METER_FLASH_EN
  logic half;
  logic [13:0] shown;
  assign half = presc >= PW'(TICK_DIV / 2);
  assign shown = write ? cap : last;
  assign blank_n = shown == 14'd0 ? half : shown < 14'(LOW_THRESH) ? shown[0] : 1'b0;
`else
  assign blank_n = 1'b0;
`endif
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      presc <= '0;
      tm <= '0;
      cap <= '0;
      last <= '0;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      bcd_out <= '0;
      blank <= 1'b0;
    end else begin
      state <= state_n;
      presc <= (preset || tick) ? '0 : presc + PW'(1);
      tm <= tm_n;
      if (restart) begin
        cap <= tm;
        bin <= tm;
        bcd <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        bcd <= {bcd_adj[14:0], bin[13]};
        bin <= bin << 1;
        cnt <= cnt + 4'd1;
      end
      if (write) begin
        bcd_out <= bcd;
        last <= cap;
      end
      blank <= blank_n;
    end
  end
endmodule
